// File: rtl/repeat_check_if.sv
// Sample/result bundle for the repeat-N run-length and sequence checker.
interface repeat_check_if;
    logic       en;
    logic [1:0] cnt_in;
    logic       err_clr;
    logic       run_done;
    logic [3:0] run_len;
    logic       locked;
    logic       err_short;
    logic       err_long;
    logic       err_seq;

    // Stimulus side: drives samples, observes results
    modport master (
        output en, cnt_in, err_clr,
        input  run_done, run_len, locked, err_short, err_long, err_seq
    );

    // Checker side
    modport slave (
        input  en, cnt_in, err_clr,
        output run_done, run_len, locked, err_short, err_long, err_seq
    );
endinterface

// File: rtl/repeat_check.sv
// Run-length and sequence checker for a repeat-N counter stream.
// Measures how many enabled samples each value is held, checks each run is
// exactly REPEAT long and that values step 0..WRAP-1 in order, and reports
// per-run results, a lock indication and sticky error flags.
module repeat_check #(
    parameter int REPEAT    = 5,
    parameter int WRAP      = 3,
    parameter int LOCK_RUNS = 2
) (
    input  logic          clk,
    input  logic          rst,
    repeat_check_if.slave bus
);
    localparam logic [3:0] RUN_LEN  = 4'(REPEAT);
    localparam logic [1:0] LAST_VAL = 2'(WRAP - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_RUNS);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t     state_q, state_d;
    // primed_q marks that SYNC has captured its first sample; without it a
    // first value different from the reset prev would look like a change.
    logic       primed_q, primed_d;
    logic [1:0] prev_q, prev_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic       run_done_q, run_done_d;
    logic [3:0] run_len_q, run_len_d;
    logic       locked_q, locked_d;
    logic       err_short_q, err_short_d;
    logic       err_long_q, err_long_d;
    logic       err_seq_q, err_seq_d;

    logic [1:0] exp_next;
    logic       seq_bad;
    logic [3:0] good_inc;

    // Registered state and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            primed_q    <= 1'b0;
            prev_q      <= '0;
            run_cnt_q   <= '0;
            good_cnt_q  <= '0;
            run_done_q  <= 1'b0;
            run_len_q   <= '0;
            locked_q    <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            primed_q    <= primed_d;
            prev_q      <= prev_d;
            run_cnt_q   <= run_cnt_d;
            good_cnt_q  <= good_cnt_d;
            run_done_q  <= run_done_d;
            run_len_q   <= run_len_d;
            locked_q    <= locked_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_seq_q   <= err_seq_d;
        end
    end

    // Next-state: sync acquisition, run counting and run-end checks
    always_comb begin
        state_d     = state_q;
        primed_d    = primed_q;
        prev_d      = prev_q;
        run_cnt_d   = run_cnt_q;
        good_cnt_d  = good_cnt_q;
        run_done_d  = 1'b0;
        run_len_d   = run_len_q;
        locked_d    = locked_q;
        // Clear first so any flag set below in the same cycle wins
        err_short_d = bus.err_clr ? 1'b0 : err_short_q;
        err_long_d  = bus.err_clr ? 1'b0 : err_long_q;
        err_seq_d   = bus.err_clr ? 1'b0 : err_seq_q;

        exp_next = (prev_q == LAST_VAL) ? 2'd0 : prev_q + 2'd1;
        seq_bad  = (bus.cnt_in != exp_next);
        good_inc = (good_cnt_q >= LOCK_N) ? LOCK_N : good_cnt_q + 4'd1;

        if (bus.en) begin
            unique case (state_q)
                SYNC: begin
                    if (!primed_q) begin
                        primed_d = 1'b1;
                        prev_d   = bus.cnt_in;
                    end else if (bus.cnt_in != prev_q) begin
                        // First observed change: phase is now known
                        prev_d    = bus.cnt_in;
                        run_cnt_d = 4'd1;
                        state_d   = TRACK;
                    end
                end
                TRACK: begin
                    if (bus.cnt_in == prev_q) begin
                        run_cnt_d = (run_cnt_q == 4'd15) ? 4'd15 : run_cnt_q + 4'd1;
                        // Fires only on the step from REPEAT to REPEAT+1
                        if (run_cnt_q == RUN_LEN) begin
                            err_long_d = 1'b1;
                            good_cnt_d = '0;
                            locked_d   = 1'b0;
                        end
                    end else begin
                        run_done_d = 1'b1;
                        run_len_d  = run_cnt_q;
                        if (run_cnt_q < RUN_LEN)
                            err_short_d = 1'b1;
                        if (seq_bad)
                            err_seq_d = 1'b1;
                        if (run_cnt_q == RUN_LEN && !seq_bad) begin
                            good_cnt_d = good_inc;
                            if (good_inc == LOCK_N)
                                locked_d = 1'b1;
                        end else begin
                            good_cnt_d = '0;
                            locked_d   = 1'b0;
                        end
                        prev_d    = bus.cnt_in;
                        run_cnt_d = 4'd1;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    assign bus.run_done  = run_done_q;
    assign bus.run_len   = run_len_q;
    assign bus.locked    = locked_q;
    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;
    assign bus.err_seq   = err_seq_q;
endmodule
